// File: rtl/gtrefclk_ctrl_pkg.sv
// Shared types and constants for the GT reference-clock buffer controller.
package gtrefclk_ctrl_pkg;

    localparam int unsigned FAULT_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_WAKE    = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

endpackage

// File: rtl/refclk_edge_sync.sv
// Brings the refclk-domain toggle into i_clk and turns each transition into a one-cycle pulse.
module refclk_edge_sync (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_tgl,
    output logic o_edge
);

    logic tgl_meta;
    logic tgl_sync;
    logic tgl_dly;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            tgl_meta <= 1'b0;
            tgl_sync <= 1'b0;
            tgl_dly  <= 1'b0;
        end else begin
            tgl_meta <= i_tgl;
            tgl_sync <= tgl_meta;
            tgl_dly  <= tgl_sync;
        end
    end

    assign o_edge = tgl_sync ^ tgl_dly;

endmodule

// File: rtl/gtrefclk_ctrl.sv
// Sequences IBUFDS_GTE2 CEB, qualifies the reference clock by edge counting per
// window, and holds the downstream GT in reset until the clock is locked.
module gtrefclk_ctrl
    import gtrefclk_ctrl_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES = 64,
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned MIN_EDGES    = 480,
    parameter int unsigned MAX_EDGES    = 544,
    parameter int unsigned LOCK_WINDOWS = 4,
    parameter int unsigned RETRY_CYCLES = 256,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_refclk_tgl,
    input  logic                   i_force_off,
    output logic                   o_ceb,
    output logic                   o_refclk_ok,
    output logic                   o_gt_rst,
    output logic [CNT_W-1:0]       o_edge_cnt,
    output logic [FAULT_CNT_W-1:0] o_fault_cnt,
    output logic [2:0]             o_state
);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_WINDOWS - 1);
    localparam logic [CNT_W-1:0] MIN_E      = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MAX_E      = CNT_W'(MAX_EDGES);

    state_t           state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_acc;
    logic [CNT_W-1:0] good_cnt;

    logic             tgl_edge;
    logic [CNT_W-1:0] edge_next;
    logic             win_end;
    logic             win_good;

    refclk_edge_sync u_sync (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_tgl  (i_refclk_tgl),
        .o_edge (tgl_edge)
    );

    // edge_next already includes an edge landing on the terminal cycle of a window
    always_comb begin
        edge_next = edge_acc;
        if (tgl_edge && (edge_acc != '1)) begin
            edge_next = edge_acc + 1'b1;
        end
    end

    assign win_end  = (win_cnt == WIN_LAST);
    assign win_good = (edge_next >= MIN_E) && (edge_next <= MAX_E);
    assign o_state  = state;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state       <= ST_OFF;
            o_ceb       <= 1'b1;
            o_refclk_ok <= 1'b0;
            o_gt_rst    <= 1'b1;
            o_edge_cnt  <= '0;
            o_fault_cnt <= '0;
            cyc_cnt     <= '0;
            win_cnt     <= '0;
            edge_acc    <= '0;
            good_cnt    <= '0;
        end else if (i_force_off) begin
            state       <= ST_OFF;
            o_ceb       <= 1'b1;
            o_refclk_ok <= 1'b0;
            o_gt_rst    <= 1'b1;
            cyc_cnt     <= '0;
            win_cnt     <= '0;
            edge_acc    <= '0;
            good_cnt    <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state   <= ST_WAKE;
                    cyc_cnt <= '0;
                end

                ST_WAKE: begin
                    if (cyc_cnt == PWRUP_LAST) begin
                        state    <= ST_MEASURE;
                        o_ceb    <= 1'b0;
                        cyc_cnt  <= '0;
                        win_cnt  <= '0;
                        edge_acc <= '0;
                        good_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                ST_MEASURE, ST_LOCKED: begin
                    if (win_end) begin
                        win_cnt    <= '0;
                        edge_acc   <= '0;
                        o_edge_cnt <= edge_next;
                        if (state == ST_MEASURE) begin
                            if (!win_good) begin
                                good_cnt <= '0;
                            end else if (good_cnt == LOCK_LAST) begin
                                state       <= ST_LOCKED;
                                o_refclk_ok <= 1'b1;
                                o_gt_rst    <= 1'b0;
                                good_cnt    <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else if (!win_good) begin
                            state       <= ST_FAULT;
                            o_ceb       <= 1'b1;
                            o_refclk_ok <= 1'b0;
                            o_gt_rst    <= 1'b1;
                            cyc_cnt     <= '0;
                            if (o_fault_cnt != '1) begin
                                o_fault_cnt <= o_fault_cnt + 1'b1;
                            end
                        end
                    end else begin
                        win_cnt  <= win_cnt + 1'b1;
                        edge_acc <= edge_next;
                    end
                end

                ST_FAULT: begin
                    if (cyc_cnt == RETRY_LAST) begin
                        state   <= ST_WAKE;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                default: begin
                    state       <= ST_OFF;
                    o_ceb       <= 1'b1;
                    o_refclk_ok <= 1'b0;
                    o_gt_rst    <= 1'b1;
                    cyc_cnt     <= '0;
                    win_cnt     <= '0;
                    edge_acc    <= '0;
                    good_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gtrefclk_ctrl.sv
// Self-checking bench for gtrefclk_ctrl: planned stimulus per window with expected
// checkpoints, plus a small-parameter instance for fault-counter saturation.
module tb_gtrefclk_ctrl;

    localparam int NS      = 8192;
    localparam int S_OFF   = 0;
    localparam int S_WAKE  = 1;
    localparam int S_MEAS  = 2;
    localparam int S_LOCK  = 3;
    localparam int S_FAULT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst, tgl, force_off;
    logic        ceb, ok, gt;
    logic [15:0] ecnt;
    logic [7:0]  fcnt;
    logic [2:0]  st;

    logic        nrst2, tgl2, force2;
    logic        ceb2, ok2, gt2;
    logic [15:0] ecnt2;
    logic [7:0]  fcnt2;
    logic [2:0]  st2;

    gtrefclk_ctrl #(
        .PWRUP_CYCLES(8), .WINDOW(100), .MIN_EDGES(45), .MAX_EDGES(55),
        .LOCK_WINDOWS(3), .RETRY_CYCLES(20), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_nrst(nrst), .i_refclk_tgl(tgl), .i_force_off(force_off),
        .o_ceb(ceb), .o_refclk_ok(ok), .o_gt_rst(gt),
        .o_edge_cnt(ecnt), .o_fault_cnt(fcnt), .o_state(st)
    );

    gtrefclk_ctrl #(
        .PWRUP_CYCLES(2), .WINDOW(16), .MIN_EDGES(4), .MAX_EDGES(12),
        .LOCK_WINDOWS(1), .RETRY_CYCLES(4), .CNT_W(16)
    ) dut_sat (
        .i_clk(clk), .i_nrst(nrst2), .i_refclk_tgl(tgl2), .i_force_off(force2),
        .o_ceb(ceb2), .o_refclk_ok(ok2), .o_gt_rst(gt2),
        .o_edge_cnt(ecnt2), .o_fault_cnt(fcnt2), .o_state(st2)
    );

    typedef struct {
        int    edge_n;
        string name;
        int    st;
        int    fault;
        int    ecnt;
        bit    chk_ecnt;
    } chk_t;

    typedef struct {
        int n;
        bit last;
        int exp_cnt;
        int exp_state;
        int exp_fault;
    } vec_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    bit   tg[NS];
    bit   fo[NS];
    chk_t q[$];
    int   max_edge;

    // Model: state reached after each window, consecutive-good count, faults, next window end.
    int m_state, m_good, m_faults, m_T;

    task automatic cmp(input string name, input int edge_n, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d, want %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic push(input int e, input string nm, input int s, input int f,
                        input int c, input bit cc);
        chk_t x;
        x.edge_n = e; x.name = nm; x.st = s; x.fault = f; x.ecnt = c; x.chk_ecnt = cc;
        q.push_back(x);
        if (e > max_edge) max_edge = e;
    endtask

    task automatic check_edge(input int k);
        foreach (q[i]) begin
            if (q[i].edge_n == k) begin
                cmp({q[i].name, ".state"}, k, int'(st), q[i].st);
                cmp({q[i].name, ".ceb"}, k, int'(ceb),
                    (q[i].st == S_MEAS || q[i].st == S_LOCK) ? 0 : 1);
                cmp({q[i].name, ".ok"}, k, int'(ok), (q[i].st == S_LOCK) ? 1 : 0);
                cmp({q[i].name, ".gt_rst"}, k, int'(gt), (q[i].st == S_LOCK) ? 0 : 1);
                cmp({q[i].name, ".fault_cnt"}, k, int'(fcnt), q[i].fault);
                if (q[i].chk_ecnt) cmp({q[i].name, ".edge_cnt"}, k, int'(ecnt), q[i].ecnt);
            end
        end
    endtask

    // Reset the main DUT, wipe the plan; edge 0 is the moment reset is released.
    task automatic start_phase();
        q.delete();
        max_edge = 0;
        foreach (tg[i]) begin
            tg[i] = 1'($urandom_range(0, 1));
            fo[i] = 1'b0;
        end
        nrst = 1'b0; tgl = 1'b0; force_off = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        m_faults = 0;
        push(0, "reset", S_OFF, 0, 0, 1);
        push(1, "off_exit", S_WAKE, 0, 0, 0);
    endtask

    task automatic entry(input int e);
        push(e - 1, "wake_end", S_WAKE, m_faults, 0, 0);
        push(e, "meas_entry", S_MEAS, m_faults, 0, 0);
        m_state = S_MEAS;
        m_good  = 0;
        m_T     = e + 100;
    endtask

    // A toggle driven in slot s is counted at edge s+3, so the window ending at
    // edge T counts slots T-102..T-3. n<0 keeps the slots already in tg[].
    task automatic plan_window(input int n, input bit last, input bit frc, input bit do_push,
                               output int c);
        int lo, hi, k, s;
        bit good;
        lo = m_T - 102;
        hi = m_T - 3;
        if (n >= 0) begin
            for (int i = lo; i <= hi; i++) tg[i] = 1'b0;
            k = n;
            if (last && n > 0) begin
                tg[hi] = 1'b1;
                k--;
            end
            while (k > 0) begin
                s = $urandom_range(lo, last ? hi - 1 : hi);
                if (!tg[s]) begin
                    tg[s] = 1'b1;
                    k--;
                end
            end
        end
        c = 0;
        for (int i = lo; i <= hi; i++) c += int'(tg[i]);
        good = (c >= 45) && (c <= 55);
        if (frc) begin
            fo[m_T - 1] = 1'b1;
            m_state = S_OFF;
        end else if (m_state == S_MEAS) begin
            m_good = good ? m_good + 1 : 0;
            if (m_good == 3) m_state = S_LOCK;
        end else if (!good) begin
            m_state = S_FAULT;
            if (m_faults < 255) m_faults++;
        end
        if (do_push) push(m_T, "window", m_state, m_faults, c, !frc);
        if (m_state == S_FAULT) begin
            push(m_T + 19, "fault_hold", S_FAULT, m_faults, 0, 0);
            push(m_T + 20, "retry_wake", S_WAKE, m_faults, 0, 0);
            entry(m_T + 28);
        end else if (m_state == S_OFF) begin
            push(m_T + 1, "off_release", S_WAKE, m_faults, 0, 0);
            entry(m_T + 9);
        end else begin
            m_T += 100;
        end
    endtask

    task automatic run_plan(input int last_e);
        for (int k = 0; k <= last_e; k++) begin
            check_edge(k);
            if (k < last_e) begin
                if (tg[k]) tgl = ~tgl;
                force_off = fo[k];
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        vec_t tab[8];
        int   c, T, budget, f;
        bit   timed_out;

        nrst2 = 1'b0; tgl2 = 1'b0; force2 = 1'b0;

        tab[0] = '{45, 1'b1, 45, S_MEAS, 0};
        tab[1] = '{44, 1'b0, 44, S_MEAS, 0};
        tab[2] = '{55, 1'b1, 55, S_MEAS, 0};
        tab[3] = '{56, 1'b1, 56, S_MEAS, 0};
        tab[4] = '{45, 1'b0, 45, S_MEAS, 0};
        tab[5] = '{55, 1'b1, 55, S_MEAS, 0};
        tab[6] = '{50, 1'b1, 50, S_LOCK, 0};
        tab[7] = '{44, 1'b1, 44, S_FAULT, 1};

        // Boundary table, then retry and an asynchronous reset mid-MEASURE.
        start_phase();
        entry(9);
        for (int i = 0; i < 8; i++) begin
            T = m_T;
            plan_window(tab[i].n, tab[i].last, 1'b0, 1'b0, c);
            push(T, "table", tab[i].exp_state, tab[i].exp_fault, tab[i].exp_cnt, 1'b1);
        end
        push(845, "pre_reset", S_MEAS, 1, 44, 1'b1);
        run_plan(845);
        nrst = 1'b0;
        #1;
        cmp("async_rst.state", 845, int'(st), S_OFF);
        cmp("async_rst.ceb", 845, int'(ceb), 1);
        cmp("async_rst.ok", 845, int'(ok), 0);
        cmp("async_rst.gt_rst", 845, int'(gt), 1);
        cmp("async_rst.edge_cnt", 845, int'(ecnt), 0);
        cmp("async_rst.fault_cnt", 845, int'(fcnt), 0);

        // Toggle every 2 cycles to lock, then every 3 cycles to fault.
        start_phase();
        foreach (tg[i]) tg[i] = (i % 2 == 0);
        entry(9);
        for (int w = 0; w < 3; w++) plan_window(-1, 1'b0, 1'b0, 1'b0, c);
        for (int i = 307; i <= 406; i++) tg[i] = (i % 3 == 0);
        plan_window(-1, 1'b0, 1'b0, 1'b0, c);
        push(109, "div2_w1", S_MEAS, 0, 50, 1'b1);
        push(209, "div2_w2", S_MEAS, 0, 50, 1'b1);
        push(308, "div2_prelock", S_MEAS, 0, 50, 1'b1);
        push(309, "div2_lock", S_LOCK, 0, 50, 1'b1);
        push(409, "div3_fault", S_FAULT, 1, 33, 1'b1);
        push(429, "div3_wake", S_WAKE, 1, 0, 1'b0);
        run_plan(440);

        // No toggles: stays in MEASURE with zero counts.
        start_phase();
        entry(9);
        for (int w = 0; w < 3; w++) plan_window(0, 1'b0, 1'b0, 1'b1, c);
        push(309, "no_tgl", S_MEAS, 0, 0, 1'b1);
        run_plan(320);

        // Force-off coinciding with a bad window end while locked.
        start_phase();
        entry(9);
        for (int w = 0; w < 3; w++) plan_window(50, 1'b0, 1'b0, 1'b1, c);
        plan_window(30, 1'b0, 1'b1, 1'b1, c);
        push(409, "force_off", S_OFF, 0, 0, 1'b0);
        plan_window(50, 1'b1, 1'b0, 1'b1, c);
        run_plan(max_edge + 2);

        // Randomized windows against the model.
        start_phase();
        entry(9);
        for (int w = 0; w < 40 && m_T + 130 < NS; w++) begin
            int n;
            bit lst;
            n   = ($urandom_range(0, 9) < 7) ? $urandom_range(44, 56) : $urandom_range(0, 100);
            lst = (n > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            plan_window(n, lst, 1'b0, 1'b1, c);
        end
        run_plan(max_edge + 1);
        nrst = 1'b0;

        // Fault-counter saturation on the small instance.
        repeat (2) @(posedge clk);
        #1;
        nrst2 = 1'b1;
        cmp("sat_reset.fault_cnt", 0, int'(fcnt2), 0);
        f = 0;
        timed_out = 1'b0;
        while (f < 260 && !timed_out) begin
            budget = 0;
            while (st2 != 3'(S_FAULT) && budget < 400) begin
                if (st2 == 3'(S_MEAS) && budget % 2 == 0) tgl2 = ~tgl2;
                @(posedge clk);
                #1;
                budget++;
            end
            if (budget >= 400) begin
                n_cmp++; n_fail++; timed_out = 1'b1;
                $display("FAIL sat_timeout: no fault after %0d cycles, want fault %0d", budget, f + 1);
            end else begin
                f++;
                if (f == 1 || f == 2 || f == 254 || f == 255 || f == 256 || f == 260)
                    cmp("sat.fault_cnt", f, int'(fcnt2), (f < 255) ? f : 255);
                budget = 0;
                while (st2 == 3'(S_FAULT) && budget < 50) begin
                    @(posedge clk);
                    #1;
                    budget++;
                end
                if (budget >= 50) begin
                    n_cmp++; n_fail++; timed_out = 1'b1;
                    $display("FAIL sat_retry_timeout: still in fault after %0d cycles, want exit", budget);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
